spi_msg_framer: RTL and testbench

SPI_MSG_FRAMER -- requirements
Module: spi_msg_framer

---
 rtl/spi_msg_framer.sv | 137 +++++++++++++
 tb/tb_spi_msg_framer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_msg_framer.sv
// spi_msg_framer: frames upstream SPI FIFO messages as header + payload words.
// Define SPI_FRAMER_CSUM_EN to append a mod-2^16 checksum word to each frame.
module spi_msg_framer #(
  parameter logic [2:0] SRC_ID   = 3'd0,
  parameter logic [4:0] HDR_SYNC = 5'b10101
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        GOT_FULL_MSG,
  input  logic [7:0]  MSG_LEN,
  input  logic [15:0] FIFO_Q,
  output logic        RD_REQ,
  output logic        MSG_START,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_SOP,
  output logic        OUT_EOP,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LATCH,
    HDR,
    RD,
    WT,
`ifdef SPI_FRAMER_CSUM_EN
    PAY,
    CSUM
`else
    PAY
`endif
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  len_reg;
  logic [7:0]  cnt;
  logic [15:0] data_q;
  logic [15:0] hdr;
  logic        last;

  assign hdr  = {HDR_SYNC, SRC_ID, len_reg};
  assign last = !(cnt < len_reg);
  assign BUSY = (state != IDLE);

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      len_reg <= 8'd0;
      cnt     <= 8'd0;
      data_q  <= 16'd0;
    end else begin
      state <= state_nx;
      if (state == START) begin
        len_reg <= MSG_LEN;
        cnt     <= 8'd0;
      end
      if (state == WT) begin
        data_q <= FIFO_Q;
        cnt    <= cnt + 8'd1;
      end
    end
  end

`ifdef SPI_FRAMER_CSUM_EN
  logic [15:0] csum;

  // Sum covers header and payload words, each at its handshake.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      csum <= 16'd0;
    end else if (state == LATCH) begin
      csum <= 16'd0;
    end else if (OUT_VALID && OUT_READY
                 && (state == HDR || state == PAY)) begin
      csum <= csum + OUT_DATA;
    end
  end
`endif

  always_comb begin
    state_nx  = state;
    RD_REQ    = 1'b0;
    MSG_START = 1'b0;
    OUT_VALID = 1'b0;
    OUT_SOP   = 1'b0;
    OUT_EOP   = 1'b0;
    OUT_DATA  = data_q;
    unique case (state)
      IDLE: begin
        if (GOT_FULL_MSG) state_nx = START;
      end
      START: begin
        MSG_START = 1'b1;
        state_nx  = LATCH;
      end
      LATCH: begin
        state_nx = (len_reg == 8'd0) ? IDLE : HDR;
      end
      HDR: begin
        OUT_VALID = 1'b1;
        OUT_SOP   = 1'b1;
        OUT_DATA  = hdr;
        if (OUT_READY) state_nx = RD;
      end
      RD: begin
        RD_REQ   = 1'b1;
        state_nx = WT;
      end
      WT: begin
        state_nx = PAY;
      end
      PAY: begin
        OUT_VALID = 1'b1;
`ifdef SPI_FRAMER_CSUM_EN
        if (OUT_READY) state_nx = last ? CSUM : RD;
      end
      CSUM: begin
        OUT_VALID = 1'b1;
        OUT_EOP   = 1'b1;
        OUT_DATA  = csum;
        if (OUT_READY) state_nx = IDLE;
`else
        OUT_EOP = last;
        if (OUT_READY) state_nx = last ? IDLE : RD;
`endif
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_msg_framer.sv
// tb_spi_msg_framer: directed frames with a FIFO model and word scoreboard.
// Expected words, flags and checksum are built from the stimulus itself.
module tb_spi_msg_framer;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b0;
  logic        GOT_FULL_MSG = 1'b0;
  logic [7:0]  MSG_LEN = 8'd0;
  logic [15:0] FIFO_Q = 16'd0;
  logic        OUT_READY = 1'b0;
  logic        RD_REQ;
  logic        MSG_START;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_SOP;
  logic        OUT_EOP;
  logic        BUSY;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int ms_cnt = 0;
  int busy_cnt = 0;
  bit stall = 1'b0;

  logic [17:0] exp_q[$];
  logic [15:0] fq[$];
  logic [15:0] pay[$];

  spi_msg_framer #(.SRC_ID(3'd1), .HDR_SYNC(5'b10101)) dut (
    .SYS_CLK(SYS_CLK),
    .RST(RST),
    .GOT_FULL_MSG(GOT_FULL_MSG),
    .MSG_LEN(MSG_LEN),
    .FIFO_Q(FIFO_Q),
    .RD_REQ(RD_REQ),
    .MSG_START(MSG_START),
    .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_SOP(OUT_SOP),
    .OUT_EOP(OUT_EOP),
    .BUSY(BUSY)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Upstream FIFO: data appears the cycle after the read strobe.
  always @(posedge SYS_CLK) begin
    if (RD_REQ) FIFO_Q <= (fq.size() != 0) ? fq.pop_front() : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst();
    chk("rst_rd_req", RD_REQ, 0);
    chk("rst_msg_start", MSG_START, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_sop", OUT_SOP, 0);
    chk("rst_eop", OUT_EOP, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_data", OUT_DATA, 0);
  endtask

  // Downstream ready: always high, or 5 low cycles per offered word.
  initial begin : rdy_drv
    int w;
    logic vprev;
    w = 0;
    vprev = 1'b0;
    forever begin
      @(posedge SYS_CLK);
      #1;
      if (!stall) begin
        OUT_READY = 1'b1;
      end else begin
        if ((vprev && OUT_READY) || !OUT_VALID) w = 0;
        if (OUT_VALID) begin
          OUT_READY = (w >= 5);
          w++;
        end else begin
          OUT_READY = 1'b0;
        end
      end
      vprev = OUT_VALID;
    end
  end

  initial begin : mon
    logic pv;
    logic pr;
    logic [15:0] pd;
    logic [17:0] e;
    pv = 1'b0;
    pr = 1'b0;
    pd = 16'd0;
    forever begin
      @(negedge SYS_CLK);
      if (RST) begin
        if (RD_REQ) rd_cnt++;
        if (MSG_START) ms_cnt++;
        if (BUSY) busy_cnt++;
        if (RD_REQ) chk("rd_while_valid", OUT_VALID, 0);
        if (pv && !pr) begin
          chk("hold_valid", OUT_VALID, 1);
          chk("hold_data", OUT_DATA, pd);
        end
        if (OUT_VALID && OUT_READY) begin
          chk("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word", {OUT_SOP, OUT_EOP, OUT_DATA}, e);
          end
        end
      end
      pv = OUT_VALID;
      pr = OUT_READY;
      pd = OUT_DATA;
    end
  end

  task automatic fill_rand(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(16'($urandom));
  endtask

  task automatic launch(input int len);
    rd_cnt = 0;
    ms_cnt = 0;
    busy_cnt = 0;
    @(posedge SYS_CLK);
    #1;
    MSG_LEN = len[7:0];
    GOT_FULL_MSG = 1'b1;
    @(posedge SYS_CLK);
    #1;
    GOT_FULL_MSG = 1'b0;
    chk("start_pulse", MSG_START, 1);
    @(posedge SYS_CLK);
    #1;
    chk("start_single", MSG_START, 0);
    chk("latch_busy", BUSY, 1);
    @(posedge SYS_CLK);
    #1;
    if (len > 0) begin
      chk("hdr_latency_valid", OUT_VALID, 1);
      chk("hdr_latency_sop", OUT_SOP, 1);
    end else begin
      chk("len0_idle", BUSY, 0);
      chk("len0_no_valid", OUT_VALID, 0);
    end
  endtask

  task automatic run_frame(input int len, input bit tog);
    logic [15:0] h;
    logic [15:0] s;
    int n;
    h = {5'b10101, 3'd1, 8'(len)};
    s = h;
    fq.delete();
    if (len > 0) begin
      exp_q.push_back({2'b10, h});
      for (int i = 0; i < len; i++) begin
        fq.push_back(pay[i]);
        s = s + pay[i];
`ifdef SPI_FRAMER_CSUM_EN
        exp_q.push_back({2'b00, pay[i]});
`else
        exp_q.push_back({1'b0, i == len - 1, pay[i]});
`endif
      end
`ifdef SPI_FRAMER_CSUM_EN
      exp_q.push_back({2'b01, s});
`endif
    end
    launch(len);
    n = 0;
    while ((BUSY || exp_q.size() != 0) && n < 5000) begin
      @(posedge SYS_CLK);
      #1;
      n++;
      if (tog && BUSY && !(OUT_VALID && OUT_EOP))
        GOT_FULL_MSG = ~GOT_FULL_MSG;
      else
        GOT_FULL_MSG = 1'b0;
    end
    chk("frame_timeout", n < 5000, 1);
    chk("rd_count", rd_cnt, len);
    chk("msg_start_count", ms_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);
    if (len == 0) chk("len0_busy_cycles", busy_cnt, 2);
  endtask

  initial begin : main
    int n;
    logic [15:0] h;
    repeat (3) @(posedge SYS_CLK);
    #1;
    chk_rst();
    @(negedge SYS_CLK);
    RST = 1'b1;

    pay = '{16'h1111, 16'h2222, 16'h3333};
    run_frame(3, 1'b0);

    run_frame(0, 1'b0);

    stall = 1'b1;
    fill_rand(2);
    run_frame(2, 1'b0);
    stall = 1'b0;

    fill_rand(254);
    run_frame(254, 1'b0);

    // Abort in the middle of the second payload word.
    fill_rand(4);
    h = {5'b10101, 3'd1, 8'd4};
    exp_q.push_back({2'b10, h});
    exp_q.push_back({2'b00, pay[0]});
    fq.delete();
    for (int i = 0; i < 4; i++) fq.push_back(pay[i]);
    launch(4);
    n = 0;
    while (!(rd_cnt == 2 && OUT_VALID) && n < 200) begin
      @(posedge SYS_CLK);
      #1;
      n++;
    end
    chk("rst_reach_word2", n < 200, 1);
    RST = 1'b0;
    #1;
    chk_rst();
    repeat (3) @(posedge SYS_CLK);
    #1;
    chk_rst();
    chk("rst_sb_consumed", exp_q.size(), 0);
    fq.delete();
    @(negedge SYS_CLK);
    RST = 1'b1;
    fill_rand(2);
    run_frame(2, 1'b0);

    fill_rand(5);
    run_frame(5, 1'b1);

    fill_rand(1);
    run_frame(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
